led_mode_sequencer: RTL and testbench
=====================================

# led_mode_sequencer

Mode-selectable running-light controller for the board's four active-low user LEDs. It owns the step prescaler, a push-button mode selector and the position state machine. It drives the LEDs in one of four patterns: run right, run left, bounce or blink-all. It sits at top level between the board clock/reset, the mode button and the LED pins, and replaces free-running per-pattern counters.

## Interface
- TICK_CYCLES, 50_000_000, clocks per pattern step; must be ≥ 2; counter width $clog2(TICK_CYCLES)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required to accept a button level; used only with LED_SEQ_DEBOUNCE_EN
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset; clears all state immediately
- btn_mode  input  1  raw mode button, active-high, asynchronous to clk
- pause  input  1  synchronous level; while high, the prescaler and pattern freeze
- led  output  4  LED drive, active-low (0 = lit), registered
- mode  output  2  current mode: 0 RIGHT, 1 LEFT, 2 BOUNCE, 3 BLINK; registered
- step  output  1  one-cycle pulse coincident with each pattern advance; registered

## Operation
- Reset values: mode=0 (RIGHT), position=0, direction=up, blink phase=on, prescaler=0, step=0, led=4'b1110.
- Prescaler counts 0..TICK_CYCLES-1 while pause=0. At TICK_CYCLES-1 it wraps to 0 and the pattern advances once.
- RIGHT: lit index 0→1→2→3→0. LEFT: 3→2→1→0→3.
- BOUNCE: 0,1,2,3,2,1,0,1,… Direction reverses on reaching 3 (going up) or 0 (going down). No index repeats at an end.
- BLINK: led alternates 4'b0000 and 4'b1111, starting 4'b0000.
- In RIGHT/LEFT/BOUNCE exactly one led bit is 0.
- Button path: 2-flop synchronizer, then rising-edge detect on the accepted level. Each accepted rising edge is one press.
- Press: mode ← (mode+1) mod 4, wrapping 3→0. Prescaler cleared to 0. Pattern loads the new mode's start: RIGHT idx 0, LEFT idx 3, BOUNCE idx 0 with direction up, BLINK phase on.
- Press is accepted while pause=1. Mode and start pattern update; the prescaler stays frozen at 0.
- A held button gives one press. Release has no effect.

## Timing
- led, mode and step change on the same clk edge. No combinational input-to-output path.
- Advance: on the edge where prescaler==TICK_CYCLES-1 and pause=0, led takes the next pattern and step goes to 1 for exactly one cycle. The step period is TICK_CYCLES clocks.
- Press latency without debounce: mode/led update on the 3rd rising clk edge after btn_mode is first sampled high.
- Press latency with debounce: the 3rd edge plus DEBOUNCE_CYCLES.
- Press and wrap on the same cycle: the press wins. No step pulse; the new mode's start pattern is shown; the prescaler restarts at 0.
- pause rising on the wrap cycle: no advance. pause falling: counting resumes from the held value the next cycle.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronously), independent of clk. After deassertion, the first advance occurs TICK_CYCLES edges later.

## Configuration
- LED_SEQ_DEBOUNCE_EN defined: the synchronized button level must hold for DEBOUNCE_CYCLES consecutive cycles before the accepted level changes. Shorter pulses and glitches are ignored.
- LED_SEQ_DEBOUNCE_EN undefined: no debounce counter. The synchronized level is the accepted level, and any pulse of ≥2 clocks registers as a press. DEBOUNCE_CYCLES is unused.

## Test plan
- Reset: assert reset mid-count with TICK_CYCLES=4 → led=1110, mode=0, step=0 immediately. First step occurs 4 clocks after release, with led=1101.
- RIGHT/LEFT: TICK_CYCLES=4, 16 clocks → led 1101,1011,0111,1110. One press, then 16 clocks → led 0111 at press, then 1011,1101,1110,0111. Step pulses every 4 clocks.
- BOUNCE: two presses from reset → led 1110. Then 8 steps → indices 1,2,3,2,1,0,1,2.
- BLINK and wrap: 3 presses → mode=3, led 0000/1111 alternating each step. A 4th press → mode=0, led=1110.
- Collision and pause: press landing on the wrap cycle → no step pulse, new start pattern shown. pause=1 for 20 clocks → led and step constant. A press during pause changes mode only.
- Debounce (macro on, DEBOUNCE_CYCLES=8): 5-clock btn glitch → no mode change. 12-clock hold → exactly one mode increment, 3+8 edges after the rise.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: four-pattern active-low running light with push-button mode select.
// Define LED_SEQ_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples before a button level is accepted.
module led_mode_sequencer #(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       step
);
  localparam int TW = $clog2(TICK_CYCLES);
  typedef enum logic [1:0] {RIGHT, LEFT, BOUNCE, BLINK} mode_t;
  mode_t         mode_q, mode_d;
  logic [TW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d, bnc_idx;
  logic          dir_q, dir_d, ph_q, ph_d, step_q, step_d;
  logic [3:0]    led_q, led_d;
  logic          s1_q, s2_q, prev_q, acc, press, wrap;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          db_hit;
  assign db_hit = (s2_q != acc_q) && (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  always_comb begin
    acc_d = db_hit ? s2_q : acc_q;
    cnt_d = (s2_q == acc_q || db_hit) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  assign acc = acc_q;
`else
  logic unused_db;
  assign unused_db = (DEBOUNCE_CYCLES != 0);
  assign acc = s2_q;
`endif
  assign press = acc & ~prev_q;
  assign wrap  = ~pause & (pre_q == TW'(TICK_CYCLES - 1));
  // bounce turns around at the ends without repeating the end index
  assign bnc_idx = dir_q ? ((idx_q == 2'd3) ? 2'd2 : idx_q + 2'd1)
                         : ((idx_q == 2'd0) ? 2'd1 : idx_q - 2'd1);
  always_comb begin
    mode_d = mode_q;
    pre_d  = pre_q;
    idx_d  = idx_q;
    dir_d  = dir_q;
    ph_d   = ph_q;
    step_d = 1'b0;
    if (press) begin
      mode_d = mode_t'(mode_q + 2'd1);
      pre_d  = '0;
      idx_d  = (mode_d == LEFT) ? 2'd3 : 2'd0;
      dir_d  = 1'b1;
      ph_d   = 1'b1;
    end else if (wrap) begin
      pre_d  = '0;
      step_d = 1'b1;
      idx_d  = (mode_q == RIGHT) ? idx_q + 2'd1 :
               (mode_q == LEFT) ? idx_q - 2'd1 :
               (mode_q == BOUNCE) ? bnc_idx : idx_q;
      dir_d  = (mode_q == BOUNCE) ? (dir_q ? (idx_q != 2'd3) : (idx_q == 2'd0)) : dir_q;
      ph_d   = (mode_q == BLINK) ? ~ph_q : ph_q;
    end else if (!pause) begin
      pre_d = pre_q + 1'b1;
    end
    led_d = (mode_d == BLINK) ? {4{~ph_d}} : ~(4'b0001 << idx_d);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode_q <= RIGHT;
      pre_q  <= '0;
      idx_q  <= 2'd0;
      dir_q  <= 1'b1;
      ph_q   <= 1'b1;
      step_q <= 1'b0;
      led_q  <= 4'b1110;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      ph_q   <= ph_d;
      step_q <= step_d;
      led_q  <= led_d;
      s1_q   <= btn_mode;
      s2_q   <= s1_q;
      prev_q <= acc;
    end
  assign led  = led_q;
  assign mode = mode_q;
  assign step = step_q;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: scoreboard bench; stimulus queues timed expected output events, a negedge monitor checks them.
module tb_led_mode_sequencer;
  localparam int TICK = 4;
  localparam int DB   = 8;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif
  typedef struct {
    int         t;
    logic [3:0] led;
    logic [1:0] mode;
    logic       step;
  } ev_t;
  logic       clk = 1'b0, reset, btn_mode, pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       step;
  ev_t        q[$];
  int         cyc = 0, total = 0, bad = 0;
  int         b, off, m, pos;
  logic       done = 1'b0;
  logic [3:0] lled = 4'b1110;
  logic [1:0] lmode = 2'd0;
  logic [3:0] rt[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] lt[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [3:0] bt[6] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101};
  logic [3:0] kt[2] = '{4'b0000, 4'b1111};

  led_mode_sequencer #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .pause(pause),
    .led(led), .mode(mode), .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] tbl(input int mm, input int p);
    return (mm == 0) ? rt[p] : (mm == 1) ? lt[p] : (mm == 2) ? bt[p] : kt[p];
  endfunction

  function automatic int len(input int mm);
    return (mm == 2) ? 6 : (mm == 3) ? 2 : 4;
  endfunction

  task automatic push(input int t, input logic [3:0] l, input logic [1:0] mm, input logic s);
    q.push_back('{t, l, mm, s});
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sched(input int t);
    while (b + TICK <= t) begin
      b += TICK;
      pos = (pos + 1) % len(m);
      push(b, tbl(m, pos), m[1:0], 1'b1);
    end
  endtask

  task automatic go(input int n);
    int t;
    t = cyc + n;
    sched(t);
    wait_cyc(t);
  endtask

  task automatic press();
    int c, p;
    c = cyc;
    p = c + LAT;
    btn_mode = 1'b1;
    if (!pause) sched(p - 1);
    m = (m + 1) % 4;
    pos = 0;
    push(p, tbl(m, 0), m[1:0], 1'b0);
    if (pause) off = 0;
    else b = p;
    wait_cyc(c + LAT + 1);
    btn_mode = 1'b0;
    if (!pause) sched(c + 2 * LAT + 2);
    wait_cyc(c + 2 * LAT + 2);
  endtask

  task automatic pause_on();
    pause = 1'b1;
    off = cyc - b;
  endtask

  task automatic pause_off();
    pause = 1'b0;
    b = cyc - off;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (led !== 4'b1110 || mode !== 2'd0 || step !== 1'b0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d: got led=%b mode=%0d step=%b, want led=1110 mode=0 step=0", cyc, led, mode, step);
      end
      lled = 4'b1110;
      lmode = 2'd0;
    end else if (step !== 1'b0 || led !== lled || mode !== lmode) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d: got led=%b mode=%0d step=%b, want no change", cyc, led, mode, step);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.t != cyc || e.led !== led || e.mode !== mode || e.step !== step) begin
          bad++;
          $display("FAIL event: got cyc=%0d led=%b mode=%0d step=%b, want cyc=%0d led=%b mode=%0d step=%b",
                   cyc, led, mode, step, e.t, e.led, e.mode, e.step);
        end
      end
      lled = led;
      lmode = mode;
    end
    if (done) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL leftover_events: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset = 1'b1;
    btn_mode = 1'b0;
    pause = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    b = cyc; m = 0; pos = 0;
    go(6);
    reset = 1'b1;
    wait_cyc(cyc + 2);
    reset = 1'b0;
    b = cyc; m = 0; pos = 0;
    go(16);
    press();
    go(16);
    press();
    go(32);
    press();
    go(12);
    t = b + TICK;
    while (t - LAT < cyc) t += TICK;
    sched(t - LAT);
    wait_cyc(t - LAT);
    press();
    go(8);
    t = b + TICK - 1;
    sched(t);
    wait_cyc(t);
    pause_on();
    wait_cyc(cyc + 20);
    press();
`ifdef LED_SEQ_DEBOUNCE_EN
    btn_mode = 1'b1;
    wait_cyc(cyc + 5);
    btn_mode = 1'b0;
    wait_cyc(cyc + 20);
`endif
    pause_off();
    go(14);
    pause_on();
    wait_cyc(cyc + 7);
    pause_off();
    go(12);
    done = 1'b1;
  end
endmodule
